// File: rtl/parking_pkg.sv
// Shared constants, FSM state type and slot-search helper for the car park
// occupancy controller.
package parking_pkg;

  localparam int unsigned N_SLOTS = 4;
  localparam int unsigned SLOT_W  = 2;
  localparam int unsigned CAP_W   = 3;

  // E-vector patterns: all slots taken / all slots free.
  localparam logic [N_SLOTS-1:0] FULL_MASK  = 4'b0000;
  localparam logic [N_SLOTS-1:0] EMPTY_MASK = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTER  = 2'd1,
    LEAVE  = 2'd2,
    REJECT = 2'd3
  } park_state_t;

  // Index of the lowest set bit of the free-flag vector; 0 when none is set.
  function automatic logic [SLOT_W-1:0] lowest_free(input logic [N_SLOTS-1:0] e);
    logic [SLOT_W-1:0] idx;
    logic              found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (e[i] && !found) begin
        idx   = SLOT_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/parking_input_conditioner.sv
// Conditions one raw push-button/sensor input: 2-FF synchronizer, optional
// debounce filter, then rising-edge detection giving one 1-cycle pulse per
// press. Debounce is built only when PARKING_DEBOUNCE_EN is defined.
module parking_input_conditioner
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_level;

  // A zero-depth filter could never settle, so reject it at elaboration.
  if (DEBOUNCE_CYCLES == 0) begin : g_bad_depth
    $error("DEBOUNCE_CYCLES must be nonzero");
  end

  // Two-stage synchronizer for the asynchronous raw input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PARKING_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 != r_level) begin
      if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_level = r_level;
`else
  assign w_level = r_sync2;
`endif

  // Previous conditioned level, for rising-edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_pulse = w_level & ~r_prev;

endmodule

// File: rtl/parking_slot_controller.sv
// Occupancy controller for a 4-slot car park: conditions entry/exit requests,
// allocates and frees slots, and drives barrier/reject strobes for GATE_CYCLES
// cycles. Optional input debounce is enabled by defining PARKING_DEBOUNCE_EN.
module parking_slot_controller
  import parking_pkg::*;
#(
  parameter int unsigned GATE_CYCLES     = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       car_in,
  input  logic       car_out,
  input  logic [1:0] out_slot,
  output logic [1:0] location,
  output logic [2:0] capacity,
  output logic [3:0] E,
  output logic       gate_in,
  output logic       gate_out,
  output logic       reject
);

  localparam int unsigned TMR_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYCLES - 1);

  logic w_in_pulse;
  logic w_out_pulse;

  park_state_t         r_state;
  logic [N_SLOTS-1:0]  r_e;
  logic [CAP_W-1:0]    r_cap;
  logic [SLOT_W-1:0]   r_location;
  logic [SLOT_W-1:0]   r_slot;
  logic [TMR_W-1:0]    r_timer;
  logic                r_pend_in;
  logic                r_pend_out;
  logic                r_gate_in;
  logic                r_gate_out;
  logic                r_reject;

  parking_input_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond_in (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_raw   (car_in),
    .o_pulse (w_in_pulse)
  );

  parking_input_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond_out (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_raw   (car_out),
    .o_pulse (w_out_pulse)
  );

  // Registered lowest-free-slot encoder; lags E by one cycle, which is safe
  // because every allocation is preceded by at least one gate-state cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_location <= '0;
    end else if (r_e == FULL_MASK) begin
      r_location <= '0;
    end else begin
      r_location <= lowest_free(r_e);
    end
  end

  // Pending-request capture, exit-first arbitration, slot bookkeeping and
  // gate timing. The IDLE-state clears are written after the captures so that
  // they win; a pulse landing on an already-set flag is dropped either way.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_e        <= EMPTY_MASK;
      r_cap      <= CAP_W'(N_SLOTS);
      r_slot     <= '0;
      r_timer    <= '0;
      r_pend_in  <= 1'b0;
      r_pend_out <= 1'b0;
      r_gate_in  <= 1'b0;
      r_gate_out <= 1'b0;
      r_reject   <= 1'b0;
    end else begin
      if (w_in_pulse && !r_pend_in) begin
        r_pend_in <= 1'b1;
      end
      if (w_out_pulse && !r_pend_out) begin
        r_pend_out <= 1'b1;
        r_slot     <= out_slot;
      end

      unique case (r_state)
        IDLE: begin
          if (r_pend_out) begin
            r_pend_out <= 1'b0;
            r_timer    <= TMR_LOAD;
            if (!r_e[r_slot]) begin
              r_e[r_slot] <= 1'b1;
              r_cap       <= r_cap + 1'b1;
              r_gate_out  <= 1'b1;
              r_state     <= LEAVE;
            end else begin
              r_reject <= 1'b1;
              r_state  <= REJECT;
            end
          end else if (r_pend_in) begin
            r_pend_in <= 1'b0;
            r_timer   <= TMR_LOAD;
            if (r_cap != '0) begin
              r_e[r_location] <= 1'b0;
              r_cap           <= r_cap - 1'b1;
              r_gate_in       <= 1'b1;
              r_state         <= ENTER;
            end else begin
              r_reject <= 1'b1;
              r_state  <= REJECT;
            end
          end
        end
        ENTER, LEAVE, REJECT: begin
          if (r_timer == '0) begin
            r_gate_in  <= 1'b0;
            r_gate_out <= 1'b0;
            r_reject   <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign location = r_location;
  assign capacity = r_cap;
  assign E        = r_e;
  assign gate_in  = r_gate_in;
  assign gate_out = r_gate_out;
  assign reject   = r_reject;

endmodule
